regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between several write-back sources (e.g. ALU, load unit, CSR unit).
- Per-requester valid/ready handshake; round-robin grant; one registered write per cycle toward the register file.
- Writes to x0 are accepted and dropped, so x0 stays 0.
- Sits between the execute/memory write-back stages and the register-file write port.

---
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register-file write port
// Optional macro WB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.

package nebula;
  typedef logic [31:0] x_t;
endpackage

module regfile_wb_arbiter #(
  parameter  int NumRequesters = 2,
  localparam int IdxW          = $clog2(NumRequesters)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NumRequesters-1:0]      req_valid_i,
  output logic [NumRequesters-1:0]      req_ready_o,
  input  logic [NumRequesters-1:0][4:0] req_addr_i,
  input  nebula::x_t [NumRequesters-1:0] req_data_i,
  output logic                          wr_en_o,
  output logic [4:0]                    wr_addr_o,
  output nebula::x_t                    wr_data_o,
  output logic [IdxW-1:0]               grant_idx_o,
  output logic                          x0_drop_o
);

  logic [IdxW-1:0] w_ptr;
  logic [IdxW-1:0] w_winner;
  logic            w_found;
  logic [4:0]      w_addr;
  nebula::x_t      w_data;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IdxW-1:0] r_ptr;
  assign w_ptr = r_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_winner == IdxW'(NumRequesters - 1)) ? '0 : w_winner + IdxW'(1);
    end
  end
`endif

  // Scan from the farthest offset down so the source closest to the pointer wins last.
  always_comb begin : arbitrate
    int v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      v_idx = (int'(w_ptr) + k) % NumRequesters;
      if (req_valid_i[v_idx]) begin
        w_found  = 1'b1;
        w_winner = IdxW'(v_idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_n_i && w_found) begin
      req_ready_o[w_winner] = 1'b1;
    end
  end

  assign w_addr = req_addr_i[w_winner];
  assign w_data = req_data_i[w_winner];

  // A transfer to x0 still updates address/data/index so the drop is observable.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_en_o     <= 1'b0;
      wr_addr_o   <= 5'd0;
      wr_data_o   <= '0;
      grant_idx_o <= '0;
      x0_drop_o   <= 1'b0;
    end else if (w_found) begin
      wr_en_o     <= (w_addr != 5'd0);
      wr_addr_o   <= w_addr;
      wr_data_o   <= w_data;
      grant_idx_o <= w_winner;
      x0_drop_o   <= (w_addr == 5'd0);
    end else begin
      wr_en_o     <= 1'b0;
      x0_drop_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter (2- and 4-source builds)

module tb_regfile_wb_arbiter;

`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        idx;
    logic        drop;
  } exp_t;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  logic             rst2;
  logic [1:0]       v2;
  logic [1:0]       r2;
  logic [1:0][4:0]  a2;
  nebula::x_t [1:0] d2;
  logic             en2;
  logic [4:0]       wa2;
  nebula::x_t       wd2;
  logic [0:0]       gi2;
  logic             xd2;

  logic             rst4;
  logic [3:0]       v4;
  logic [3:0]       r4;
  logic [3:0][4:0]  a4;
  nebula::x_t [3:0] d4;
  logic             en4;
  logic [4:0]       wa4;
  nebula::x_t       wd4;
  logic [1:0]       gi4;
  logic             xd4;

  logic [4:0]  h_addr;
  logic [31:0] h_data;
  logic        h_idx;

  regfile_wb_arbiter #(.NumRequesters(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst2), .req_valid_i(v2), .req_ready_o(r2),
    .req_addr_i(a2), .req_data_i(d2), .wr_en_o(en2), .wr_addr_o(wa2),
    .wr_data_o(wd2), .grant_idx_o(gi2), .x0_drop_o(xd2)
  );

  regfile_wb_arbiter #(.NumRequesters(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst4), .req_valid_i(v4), .req_ready_o(r4),
    .req_addr_i(a4), .req_data_i(d4), .wr_en_o(en4), .wr_addr_o(wa4),
    .wr_data_o(wd4), .grant_idx_o(gi4), .x0_drop_o(xd4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic [1:0] exp_rdy, input string tag);
    exp_t e;
    exp_t got;
    logic w;
    rst2 = rst; v2 = v; a2[0] = a0; d2[0] = d0; a2[1] = a1; d2[1] = d1;
    #1;
    chk({tag, "_ready"}, 32'(r2), 32'(exp_rdy));
    if (!rst) begin
      h_addr = 5'd0; h_data = 32'd0; h_idx = 1'b0;
      e = '{en: 1'b0, addr: 5'd0, data: 32'd0, idx: 1'b0, drop: 1'b0};
    end else if (exp_rdy != 2'b00) begin
      w = exp_rdy[1];
      h_addr = w ? a1 : a0;
      h_data = w ? d1 : d0;
      h_idx  = w;
      e = '{en: (h_addr != 5'd0), addr: h_addr, data: h_data, idx: h_idx, drop: (h_addr == 5'd0)};
    end else begin
      e = '{en: 1'b0, addr: h_addr, data: h_data, idx: h_idx, drop: 1'b0};
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk({tag, "_wr_en"},   32'(en2), 32'(got.en));
    chk({tag, "_wr_addr"}, 32'(wa2), 32'(got.addr));
    chk({tag, "_wr_data"}, wd2,      got.data);
    chk({tag, "_grant"},   32'(gi2), 32'(got.idx));
    chk({tag, "_x0_drop"}, 32'(xd2), 32'(got.drop));
  endtask

  task automatic step4(input logic [3:0] v, input logic [3:0] exp_rdy,
                       input logic exp_en, input logic [1:0] exp_idx, input string tag);
    v4 = v;
    #1;
    chk({tag, "_ready"}, 32'(r4), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, "_wr_en"}, 32'(en4), 32'(exp_en));
    chk({tag, "_grant"}, 32'(gi4), 32'(exp_idx));
  endtask

  initial begin
    h_addr = 5'd0; h_data = 32'd0; h_idx = 1'b0;
    rst4 = 1'b0; v4 = 4'b0000;
    a4[0] = 5'd1; a4[1] = 5'd2; a4[2] = 5'd3; a4[3] = 5'd4;
    d4[0] = 32'h40; d4[1] = 32'h41; d4[2] = 32'h42; d4[3] = 32'h43;

    step(1'b0, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 2'b00, "rst0");
    step(1'b0, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 2'b00, "rst1");
    step(1'b0, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 2'b00, "rst2");

    step(1'b1, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 2'b01, "cont0");
    step(1'b1, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, Fixed ? 2'b01 : 2'b10, "cont1");
    step(1'b1, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, 2'b01, "cont2");
    step(1'b1, 2'b11, 5'd1, 32'h1111_0000, 5'd2, 32'h2222_0000, Fixed ? 2'b01 : 2'b10, "cont3");
    step(1'b1, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, "idle0");

    step(1'b1, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b01, "single");
    step(1'b1, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 2'b00, "single_after");

    step(1'b1, 2'b10, 5'd3, 32'h9999, 5'd0, 32'h1234, 2'b10, "x0");
    step(1'b1, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    2'b00, "x0_after");

    step(1'b1, 2'b11, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB, 2'b01, "same_dst0");
    step(1'b1, 2'b10, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB, 2'b10, "same_dst1");

    step(1'b1, 2'b01, 5'd8,  32'h5555, 5'd9, 32'h6666, 2'b01, "pre_rst");
    step(1'b0, 2'b10, 5'd8,  32'h5555, 5'd9, 32'h6666, 2'b00, "mid_rst");
    step(1'b1, 2'b11, 5'd10, 32'h7777, 5'd11, 32'h8888, 2'b01, "post_rst");
    step(1'b1, 2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    2'b00, "post_rst_idle");

    rst4 = 1'b1;
    step4(4'b1000, 4'b1000, 1'b1, 2'd3, "w4_src3");
    step4(4'b0100, 4'b0100, 1'b1, 2'd2, "w4_src2");
    step4(4'b0000, 4'b0000, 1'b0, 2'd2, "w4_idle");
    step4(4'b1111, Fixed ? 4'b0001 : 4'b1000, 1'b1, Fixed ? 2'd0 : 2'd3, "w4_ptr3");
    step4(4'b1111, 4'b0001, 1'b1, 2'd0, "w4_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
